avalon_poll_master: RTL and testbench

- Avalon-MM master that periodically reads one register from a slave (the ADC sample register) and writes a scaled 8-bit result to a second slave address (the LED/PWM output PIO data register at offset 0).
- It is the initiator end of the same Avalon-MM slave interface the PIO peripherals expose.
- It lets hardware drive LEDs/PWM duty from the ADC without the Nios processor.
- It sits on the system interconnect as a master, alongside the CPU.

---
 rtl/avalon_poll_master.sv | 127 ++++++++++++
 tb/tb_avalon_poll_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_poll_master.sv
// avalon_poll_master: Avalon-MM master that periodically reads a source
// register (ADC sample), scales it by a right shift and writes the low byte
// to a destination register (LED/PWM PIO data). One transaction at a time.
module avalon_poll_master #(
    parameter int                 ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]  RD_ADDR = 32'h0000_0000,
    parameter logic [ADDR_W-1:0]  WR_ADDR = 32'h0000_0010,
    parameter int unsigned        PERIOD  = 50000,
    parameter int unsigned        SHIFT   = 4,
    parameter int unsigned        TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              err_clear,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [31:0]       writedata,
    input  logic              waitrequest,
    input  logic [31:0]       readdata,
    input  logic              readdatavalid,
    output logic [7:0]        sample,
    output logic              sample_valid,
    output logic              busy,
    output logic              timeout_err
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ
    } state_t;

    state_t        state;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [31:0]   shifted;

    // Scaled view of the returned word; only the low byte is forwarded.
    assign shifted    = readdata >> SHIFT;
    assign byteenable = 4'b1111;

    // Poll sequencer: period timer, read/write handshakes and error flag.
    always_ff @(posedge clk) begin
        // NOTE: every register here, including datapath outputs, is cleared by
        // reset so the bus sees an idle master even if reset lands mid-transfer.
        if (!reset_n) begin
            state        <= IDLE;
            period_cnt   <= '0;
            timeout_cnt  <= '0;
            address      <= '0;
            read         <= 1'b0;
            write        <= 1'b0;
            writedata    <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments; a later assignment in this block
            // overrides an earlier one, which is how a timeout set beats err_clear.
            sample_valid <= 1'b0;
            if (err_clear) begin
                timeout_err <= 1'b0;
            end

            // The period timer runs in every state so poll starts stay on a
            // fixed grid; a new poll is only launched from IDLE.
            if (state == IDLE && enable && period_cnt == '0) begin
                period_cnt <= PW'(PERIOD - 1);
            end else if (period_cnt != '0) begin
                period_cnt <= period_cnt - PW'(1);
            end

            case (state)
                IDLE: begin
                    if (enable && period_cnt == '0) begin
                        address <= RD_ADDR;
                        read    <= 1'b1;
                        busy    <= 1'b1;
                        state   <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (!waitrequest) begin
                        read        <= 1'b0;
                        timeout_cnt <= TW'(TIMEOUT);
                        state       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (readdatavalid) begin
                        writedata <= {24'b0, shifted[7:0]};
                        address   <= WR_ADDR;
                        write     <= 1'b1;
                        state     <= WR_REQ;
                    end else if (timeout_cnt == TW'(1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt - TW'(1);
                    end
                end
                WR_REQ: begin
                    if (!waitrequest) begin
                        write        <= 1'b0;
                        sample       <= writedata[7:0];
                        sample_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_poll_master.sv
// tb_avalon_poll_master: reactive Avalon slave model plus scoreboard for
// avalon_poll_master (PERIOD=10, SHIFT=4, TIMEOUT=5).
module tb_avalon_poll_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        err_clear = 1'b0;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = '0;
    logic        readdatavalid = 1'b0;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        busy;
    logic        timeout_err;

    avalon_poll_master #(
        .ADDR_W (32),
        .RD_ADDR(32'h0000_0000),
        .WR_ADDR(32'h0000_0010),
        .PERIOD (10),
        .SHIFT  (4),
        .TIMEOUT(5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .err_clear    (err_clear),
        .address      (address),
        .read         (read),
        .write        (write),
        .byteenable   (byteenable),
        .writedata    (writedata),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    // Slave configuration (set by the main sequence)
    int          rd_stall   = 0;
    int          wr_stall   = 0;
    bit          drop_resp  = 1'b0;
    bit          stray_rdv  = 1'b0;
    logic [31:0] resp_data  = '0;

    // Slave / monitor state
    int          rd_seen = 0, wr_seen = 0;
    bit          pending = 1'b0;
    logic [31:0] hold_addr, hold_wd;
    bit          stable_bad = 1'b0, both_seen = 1'b0, err_prev = 1'b0;
    int          n_read_starts = 0, n_reads = 0, n_write_starts = 0, n_writes = 0, n_sv = 0;
    int          last_start = -1, last_gap = 0, last_rd_hold = 0, last_wr_hold = 0;
    int          acc_cycle = 0, err_cycle = 0, sv_cycle = 0;
    logic [7:0]  sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Slave model: decides waitrequest/readdatavalid on the falling edge and
    // monitors handshakes, hold stability and sample_valid against the queue.
    always @(negedge clk) begin
        if (!reset_n) begin
            rd_seen = 0; wr_seen = 0; pending = 1'b0;
            waitrequest = 1'b0; readdatavalid = 1'b0;
        end else begin
            if (pending) begin
                readdatavalid = 1'b1; readdata = resp_data; pending = 1'b0;
            end else begin
                readdatavalid = stray_rdv;
                readdata = stray_rdv ? 32'hFFFF_FFFF : 32'h0;
            end
            if (read && write) both_seen = 1'b1;
            if (timeout_err && !err_prev) err_cycle = cyc;
            err_prev = timeout_err;
            waitrequest = 1'b0;
            if (read) begin
                if (rd_seen == 0) begin
                    hold_addr = address;
                    n_read_starts++;
                    if (last_start >= 0) last_gap = cyc - last_start;
                    last_start = cyc;
                end else if (address !== hold_addr) begin
                    stable_bad = 1'b1;
                end
                rd_seen++;
                if (rd_seen <= rd_stall) begin
                    waitrequest = 1'b1;
                end else begin
                    check("rd_addr", address, 32'h0000_0000);
                    last_rd_hold = rd_seen; rd_seen = 0;
                    n_reads++; acc_cycle = cyc;
                    if (!drop_resp) begin
                        pending = 1'b1;
                        sb.push_back(8'((resp_data >> 4) & 32'hFF));
                    end
                end
            end else if (write) begin
                if (wr_seen == 0) begin
                    hold_addr = address; hold_wd = writedata; n_write_starts++;
                end else if (address !== hold_addr || writedata !== hold_wd) begin
                    stable_bad = 1'b1;
                end
                wr_seen++;
                if (wr_seen <= wr_stall) begin
                    waitrequest = 1'b1;
                end else begin
                    check("wr_addr", address, 32'h0000_0010);
                    if (sb.size() == 0) check("wr_unexpected", 1, 0);
                    else check("writedata", writedata, {24'b0, sb[0]});
                    last_wr_hold = wr_seen; wr_seen = 0; n_writes++;
                end
            end
            if (sample_valid) begin
                n_sv++; sv_cycle = cyc;
                if (sb.size() == 0) check("sv_unexpected", 1, 0);
                else check("sample", sample, sb.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Waits until a monitored count reaches target; expiry counts as a failure.
    // which: 0 read starts, 1 reads accepted, 2 writes accepted, 3 sample_valid, 4 timeout_err
    task automatic wait_cnt(input int which, input int target, input int budget);
        int v;
        for (int i = 0; i < budget; i++) begin
            case (which)
                0: v = n_read_starts;
                1: v = n_reads;
                2: v = n_writes;
                3: v = n_sv;
                default: v = int'(timeout_err);
            endcase
            if (v >= target) return;
            tick(1);
        end
        check($sformatf("wait_expired_%0d", which), 0, 1);
    endtask

    int base;

    initial begin
        // Reset state
        tick(3);
        check("rst_read", read, 0);
        check("rst_write", write, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", address, 0);
        check("rst_wd", writedata, 0);
        check("rst_sample", sample, 0);
        check("rst_sv", sample_valid, 0);
        check("rst_err", timeout_err, 0);
        check("byteenable", byteenable, 4'hF);

        // Basic poll: 0x0A50 >> 4 -> 0xA5, pulse 3 clocks after start
        reset_n = 1'b1; resp_data = 32'h0000_0A50; enable = 1'b1;
        wait_cnt(3, 1, 50);
        check("sample_a5", sample, 8'hA5);
        check("min_latency", sv_cycle - last_start, 3);
        tick(1);
        check("sv_one_cycle", sample_valid, 0);

        // Continuous polling: starts exactly PERIOD apart, one read + one write each
        resp_data = 32'h0000_1230;
        base = n_read_starts;
        for (int k = 1; k <= 3; k++) begin
            wait_cnt(0, base + k, 40);
            check("period_gap", last_gap, 10);
        end
        wait_cnt(3, base + 4, 40);
        enable = 1'b0;
        check("rd_eq_wr", n_reads, n_writes);
        check("wr_eq_starts", n_writes, n_write_starts);

        // Stalled handshakes: 3 wait cycles each -> 4-cycle holds
        tick(12);
        rd_stall = 3; wr_stall = 3; resp_data = 32'h1234_5678;
        base = n_sv;
        enable = 1'b1;
        wait_cnt(3, base + 1, 60);
        enable = 1'b0;
        check("rd_hold", last_rd_hold, 4);
        check("wr_hold", last_wr_hold, 4);
        check("hold_stable", stable_bad, 0);
        check("sample_67", sample, 8'h67);
        check("no_dup_accept", n_reads, n_writes);
        rd_stall = 0; wr_stall = 0;

        // Read timeout: no response, no write, flag after 5 clocks in RD_WAIT
        tick(12);
        drop_resp = 1'b1; base = n_writes;
        enable = 1'b1;
        wait_cnt(0, n_read_starts + 1, 30);
        enable = 1'b0;
        wait_cnt(4, 1, 30);
        check("to_latency", err_cycle - acc_cycle, 6);
        tick(2);
        check("to_no_write", n_writes, base);
        check("to_idle", busy, 0);
        drop_resp = 1'b0; resp_data = 32'hFFFF_F3C0;
        tick(12);
        enable = 1'b1;
        wait_cnt(3, n_sv + 1, 40);
        enable = 1'b0;
        check("after_to_sample", sample, 8'h3C);
        check("err_sticky", timeout_err, 1);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("err_cleared", timeout_err, 0);

        // enable dropped in RD_WAIT: write still completes, no new read after
        tick(12);
        resp_data = 32'h0000_BEEF;
        enable = 1'b1;
        wait_cnt(1, n_reads + 1, 30);
        tick(1);
        enable = 1'b0;
        check("in_rd_wait", {busy, read, write}, 3'b100);
        base = n_sv;
        wait_cnt(3, base + 1, 20);
        check("sample_ee", sample, 8'hEE);
        base = n_read_starts;
        tick(30);
        check("no_read_disabled", n_read_starts, base);
        enable = 1'b1;
        wait_cnt(0, base + 1, 20);
        wait_cnt(3, n_sv + 1, 20);
        enable = 1'b0;

        // Reset while stalled in WR_REQ, then a stray readdatavalid in IDLE
        tick(12);
        wr_stall = 100; resp_data = 32'h0000_0770;
        enable = 1'b1;
        base = n_write_starts;
        for (int i = 0; i < 40 && n_write_starts == base; i++) tick(1);
        check("in_wr_req", write, 1);
        tick(2);
        enable = 1'b0;
        reset_n = 1'b0;
        tick(1);
        check("rst_mid_write", write, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_sample", sample, 0);
        sb.delete();
        wr_stall = 0;
        reset_n = 1'b1;
        tick(1);
        base = n_sv;
        stray_rdv = 1'b1;
        tick(1);
        stray_rdv = 1'b0;
        tick(5);
        check("stray_busy", busy, 0);
        check("stray_write", write, 0);
        check("stray_sample", sample, 0);
        check("stray_sv", n_sv, base);

        check("never_rd_and_wr", both_seen, 0);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
